// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state encoding, mux codes.
// MULTICYCLE_JUMP_EN adds the JUMP state to the encoding.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10
`ifdef MULTICYCLE_JUMP_EN
    , S_JUMP   = 4'd11
`endif
  } state_e;

  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bus watchdog: counts consecutive waiting cycles without mem_ready and strobes on the TIMEOUT-th.
module mem_wait_timer
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Anything other than a continuing unsatisfied wait leaves the counter at zero,
  // so every wait state is entered with a cleared count.
  always_comb begin
    timeout_o = wait_i & ~ready_i & (count_q == CNT_W'(TIMEOUT - 1));
    if (wait_i && !ready_i && !timeout_o) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory wait states, bus watchdog and illegal-opcode pulse.
// Define MULTICYCLE_JUMP_EN to support the j instruction; otherwise j is reported illegal.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                iord,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                ALU_src_A,
  output logic [1:0]          ALU_src_B,
  output logic [1:0]          ALU_op,
  output logic [1:0]          pc_src,
  output logic                illegal_op,
  output logic                bus_error
);

  state_e state_q, state_d, decode_tgt;
  logic   decode_legal, timeout;
  logic   pc_write_s, branch_s, iord_s, ir_write_s, mem_write_s, reg_dst_s;
  logic   mem_to_reg_s, reg_write_s, src_a_s, illegal_s;
  logic [1:0] src_b_s, alu_op_s, pc_src_s;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_i   (is_wait_state(state_q)),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  always_comb begin
    decode_legal = 1'b1;
    case (opcode)
      OP_LW, OP_SW: decode_tgt = S_MEMADR;
      OP_RTYPE:     decode_tgt = S_EXECUTE;
      OP_BEQ:       decode_tgt = S_BRANCH;
      OP_ADDI:      decode_tgt = S_ADDIEXEC;
`ifdef MULTICYCLE_JUMP_EN
      OP_J:         decode_tgt = S_JUMP;
`endif
      default: begin
        decode_tgt   = S_FETCH;
        decode_legal = 1'b0;
      end
    endcase
  end

  // Wait states fall back to FETCH on watchdog expiry; mem_ready always takes precedence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_tgt;
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
        else              state_d = S_MEMREAD;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = (mem_ready || timeout) ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    src_a_s      = 1'b0;
    src_b_s      = SRCB_REG;
    alu_op_s     = ALU_ADD;
    pc_src_s     = PCSRC_ALU;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b_s    = SRCB_FOUR;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        src_b_s   = SRCB_IMM_SH;
        illegal_s = ~decode_legal;
      end
      S_MEMADR, S_ADDIEXEC: begin
        src_a_s = 1'b1;
        src_b_s = SRCB_IMM;
      end
      S_MEMREAD: iord_s = 1'b1;
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        iord_s      = 1'b1;
        mem_write_s = ~timeout;
      end
      S_EXECUTE: begin
        src_a_s  = 1'b1;
        alu_op_s = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        src_a_s  = 1'b1;
        alu_op_s = ALU_SUB;
        pc_src_s = PCSRC_ALUOUT;
        branch_s = 1'b1;
      end
      S_ADDIWB: reg_write_s = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_src_s   = PCSRC_JUMP;
        pc_write_s = 1'b1;
      end
`endif
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Outputs are forced low for as long as rst_n is held, independent of the clock.
  assign pc_en      = rst_n & (pc_write_s | (branch_s & zero));
  assign iord       = rst_n & iord_s;
  assign ir_write   = rst_n & ir_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign reg_dst    = rst_n & reg_dst_s;
  assign mem_to_reg = rst_n & mem_to_reg_s;
  assign reg_write  = rst_n & reg_write_s;
  assign ALU_src_A  = rst_n & src_a_s;
  assign ALU_src_B  = {2{rst_n}} & src_b_s;
  assign ALU_op     = {2{rst_n}} & alu_op_s;
  assign pc_src     = {2{rst_n}} & pc_src_s;
  assign illegal_op = rst_n & illegal_s;
  assign bus_error  = rst_n & timeout;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles over a shared memory and ALU. It replaces the single-cycle opcode decoder in the multicycle datapath and adds memory wait-state handshaking, a bus-timeout watchdog and illegal-opcode reporting. It drives every datapath mux select and write enable.

## Interface
- OPCODE_W, 6, opcode field width
- TIMEOUT, 15, max consecutive cycles waiting on mem_ready before bus error (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  OPCODE_W  instruction[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC load = pc_write | (branch & zero)
- iord  output  1  0 = memory address from PC, 1 = from ALUOut
- ir_write  output  1  load instruction register
- mem_write  output  1  memory write strobe
- reg_dst  output  1  1 = rd, 0 = rt
- mem_to_reg  output  1  1 = data register, 0 = ALUOut
- reg_write  output  1  register file write
- ALU_src_A  output  1  0 = PC, 1 = rs
- ALU_src_B  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALU_op  output  2  00 add, 01 sub, 10 funct-decoded
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  output  1  one-cycle pulse on unknown opcode
- bus_error  output  1  one-cycle pulse on mem_ready timeout

## Operation
- Opcodes: Rtype 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- FETCH: iord 0, ALU_src_A 0, ALU_src_B 01, ALU_op 00, pc_src 00; ir_write and pc_write asserted only when mem_ready; stays in FETCH until mem_ready.
- DECODE: ALU_src_A 0, ALU_src_B 11, ALU_op 00. Next: lw/sw → MEMADR, Rtype → EXECUTE, beq → BRANCH, addi → ADDIEXEC, j → JUMP, other → FETCH with illegal_op pulse.
- MEMADR: ALU_src_A 1, ALU_src_B 10, ALU_op 00; → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: iord 1; waits for mem_ready, then → MEMWB. MEMWB: reg_dst 0, mem_to_reg 1, reg_write 1 → FETCH.
- MEMWRITE: iord 1, mem_write held high until mem_ready; → FETCH on mem_ready.
- EXECUTE: ALU_src_A 1, ALU_src_B 00, ALU_op 10 → ALUWB (reg_dst 1, mem_to_reg 0, reg_write 1) → FETCH.
- BRANCH: ALU_src_A 1, ALU_src_B 00, ALU_op 01, pc_src 01, branch 1 → FETCH.
- ADDIEXEC: ALU_src_A 1, ALU_src_B 10, ALU_op 00 → ADDIWB (reg_dst 0, mem_to_reg 0, reg_write 1) → FETCH.
- JUMP: pc_src 10, pc_write 1 → FETCH.
- Unlisted outputs are 0 in each state.
- Watchdog: counter clears on entry to any wait state (FETCH, MEMREAD, MEMWRITE) and on mem_ready; increments each waiting cycle; when it reaches TIMEOUT without mem_ready: bus_error pulse, no write enables that cycle, → FETCH, counter cleared.

## Timing
- Reset (rst_n low, asynchronous): state FETCH, counter 0, all outputs 0 while reset held (outputs gated by rst_n).
- Outputs are combinational from state, plus mem_ready gating in wait states; next state registered on clk.
- With mem_ready tied 1: lw 5 cycles, sw 4, Rtype 4, addi 4, beq 3, j 3, illegal 2.
- Each wait cycle adds exactly one cycle; mem_ready and timeout in the same cycle: mem_ready wins.
- Reset mid-instruction aborts it; first FETCH cycle follows rst_n release.

## Configuration
- MULTICYCLE_JUMP_EN defined: j supported as above.
- Undefined: JUMP state not compiled, pc_src never 10, j opcode treated as illegal (illegal_op pulse, → FETCH).

## Structure
- Shared package: opcode constants, state encoding enum, ALU_op and pc_src/ALU_src_B codes.
- One sub-module, mem_wait_timer: watchdog counter producing the timeout strobe.

## Test plan
- mem_ready=1, opcode 100011 → state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
- opcode 000100, zero=1 → pc_en=1 in BRANCH with pc_src 01; with zero=0 pc_en=0 there.
- sw with mem_ready low 3 cycles then high → mem_write held 4 cycles, returns to FETCH next.
- mem_ready held 0 in FETCH, TIMEOUT=15 → bus_error pulse on 15th wait cycle, ir_write never asserted.
- opcode 111111 → illegal_op single pulse in DECODE, FETCH next; opcode 000010 with and without MULTICYCLE_JUMP_EN → JUMP vs illegal_op.
- rst_n dropped during MEMREAD → all outputs 0 immediately; FETCH after release.
